// File: rtl/stdp_pkg.sv
// Shared types and constants for the STDP update engine: FSM states,
// mode encodings, the LTP/LTD delta lookup tables and the saturating
// weight arithmetic used on write-back.
package stdp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LTP_SCAN,
        ST_LTD_SCAN,
        ST_RD,
        ST_WR
    } state_e;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_LTP  = 2'b01;
    localparam logic [1:0] MODE_LTD  = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam int MODE_LTP_BIT = 0;
    localparam int MODE_LTD_BIT = 1;

    localparam int NUM_BINS = 8;
    localparam int DW_WIDTH = 4;

    // Bin 0 is the shortest spike interval, so it carries the largest change.
    localparam logic [DW_WIDTH-1:0] LTP_LUT [NUM_BINS] =
        '{4'd8, 4'd6, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0};
    localparam logic [DW_WIDTH-1:0] LTD_LUT [NUM_BINS] =
        '{4'd6, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};

    // Adds or subtracts dw from w in a wide signed domain, then clamps the
    // result into the unsigned range of a 'width'-bit weight.
    function automatic logic [31:0] sat_add(input logic [31:0] w,
                                            input logic [31:0] dw,
                                            input logic        sub,
                                            input int          width);
        logic signed [33:0] sum;
        logic        [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (sub) begin
            sum = $signed({2'b00, w}) - $signed({2'b00, dw});
        end else begin
            sum = $signed({2'b00, w}) + $signed({2'b00, dw});
        end
        if (sum < 0) begin
            return 32'd0;
        end else if (sum > $signed({2'b00, max_v})) begin
            return max_v;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/stdp_update_unit_lut.sv
// Combinational STDP delta lookup: turns a spike-interval age into an
// in-window flag and the weight change magnitude for LTP or LTD.
import stdp_pkg::*;

module stdp_lut #(
    parameter int T_WIDTH   = 6,
    parameter int BIN_SHIFT = 2
) (
    input  logic [T_WIDTH-1:0]  delta,
    input  logic                ltd,
    output logic [DW_WIDTH-1:0] dw,
    output logic                in_window
);

    localparam logic [31:0] WINDOW = 32'(NUM_BINS) << BIN_SHIFT;

    logic [2:0] bin;

    // Zero interval means simultaneous spikes and is never plastic.
    always_comb begin
        bin       = 3'(delta >> BIN_SHIFT);
        in_window = (delta != '0) && (32'(delta) < WINDOW);
        dw        = '0;
        if (in_window) begin
            dw = ltd ? LTD_LUT[bin] : LTP_LUT[bin];
        end
    end

endmodule

// File: rtl/stdp_update_unit.sv
// STDP engine for one post-neuron: tracks pre/post spike ages, queues
// spike events and walks affected synapses doing read-modify-write on the
// external weight memory.
import stdp_pkg::*;

module stdp_update_unit #(
    parameter int N_SYN     = 8,
    parameter int W_WIDTH   = 8,
    parameter int T_WIDTH   = 6,
    parameter int BIN_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       kill,
    input  logic                       tick,
    input  logic [1:0]                 mode,
    input  logic [N_SYN-1:0]           pre_spike,
    input  logic                       post_spike,
    output logic                       w_rd_en,
    output logic                       w_wr_en,
    output logic [$clog2(N_SYN)-1:0]   w_addr,
    input  logic [W_WIDTH-1:0]         w_rdata,
    output logic [W_WIDTH-1:0]         w_wdata,
    output logic                       o_wait
);

    localparam int                 A_W       = $clog2(N_SYN);
    localparam logic [T_WIDTH-1:0] AGE_STALE = '1;
    localparam logic [A_W-1:0]     IDX_LAST  = A_W'(N_SYN - 1);

    state_e               state_q, state_d;
    logic [A_W-1:0]       idx_q, idx_d;
    logic [T_WIDTH-1:0]   pre_age_q [N_SYN];
    logic [T_WIDTH-1:0]   pre_age_d [N_SYN];
    logic [T_WIDTH-1:0]   snap_q [N_SYN];
    logic [T_WIDTH-1:0]   snap_d [N_SYN];
    logic [T_WIDTH-1:0]   post_age_q, post_age_d;
    logic [N_SYN-1:0]     pre_pend_q, pre_pend_d;
    logic                 post_pend_q, post_pend_d;
    logic [DW_WIDTH-1:0]  dw_q, dw_d;
    logic                 ltd_q, ltd_d;

    logic [N_SYN-1:0]     pre_clr;
    logic                 post_clr;
    logic [A_W-1:0]       low_idx;
    logic                 low_valid;
    logic [N_SYN-1:0]     pre_rem;

    logic [T_WIDTH-1:0]   lut_delta;
    logic                 lut_ltd;
    logic [DW_WIDTH-1:0]  lut_dw;
    logic                 lut_in_window;

    stdp_lut #(
        .T_WIDTH   (T_WIDTH),
        .BIN_SHIFT (BIN_SHIFT)
    ) u_lut (
        .delta     (lut_delta),
        .ltd       (lut_ltd),
        .dw        (lut_dw),
        .in_window (lut_in_window)
    );

    // Age counters: spike restarts at zero, tick ages until stale, kill forces stale.
    always_comb begin
        for (int i = 0; i < N_SYN; i++) begin
            pre_age_d[i] = pre_age_q[i];
            if (kill) begin
                pre_age_d[i] = AGE_STALE;
            end else if (pre_spike[i]) begin
                pre_age_d[i] = '0;
            end else if (tick && (pre_age_q[i] != AGE_STALE)) begin
                pre_age_d[i] = pre_age_q[i] + T_WIDTH'(1);
            end
        end
        post_age_d = post_age_q;
        if (kill) begin
            post_age_d = AGE_STALE;
        end else if (post_spike) begin
            post_age_d = '0;
        end else if (tick && (post_age_q != AGE_STALE)) begin
            post_age_d = post_age_q + T_WIDTH'(1);
        end
    end

    // Pending events accumulate; a new spike survives its own clear.
    always_comb begin
        pre_pend_d  = kill ? '0 : ((pre_pend_q & ~pre_clr) | pre_spike);
        post_pend_d = kill ? 1'b0 : ((post_pend_q & ~post_clr) | post_spike);
    end

    // Lowest pending pre channel and the set left once it is taken.
    always_comb begin
        low_valid = 1'b0;
        low_idx   = '0;
        for (int i = N_SYN - 1; i >= 0; i--) begin
            if (pre_pend_q[i]) begin
                low_valid = 1'b1;
                low_idx   = A_W'(i);
            end
        end
        pre_rem          = pre_pend_q;
        pre_rem[low_idx] = 1'b0;
    end

    // LTD uses the live post age; LTP uses the pre ages frozen at pass start.
    always_comb begin
        lut_ltd   = (state_q == ST_LTD_SCAN);
        lut_delta = lut_ltd ? post_age_q : snap_q[idx_q];
    end

    // Next-state and memory strobes; kill overrides everything to a quiet IDLE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        dw_d     = dw_q;
        ltd_d    = ltd_q;
        pre_clr  = '0;
        post_clr = 1'b0;
        w_rd_en  = 1'b0;
        w_wr_en  = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (post_pend_q) begin
                    state_d  = ST_LTP_SCAN;
                    idx_d    = '0;
                    snap_d   = pre_age_q;
                    post_clr = 1'b1;
                end else if (low_valid) begin
                    state_d = ST_LTD_SCAN;
                end
            end
            ST_LTP_SCAN: begin
                if (mode[MODE_LTP_BIT] && lut_in_window) begin
                    state_d = ST_RD;
                    dw_d    = lut_dw;
                    ltd_d   = 1'b0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + A_W'(1);
                end
            end
            ST_LTD_SCAN: begin
                if (!low_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    pre_clr[low_idx] = 1'b1;
                    idx_d            = low_idx;
                    if (mode[MODE_LTD_BIT] && lut_in_window) begin
                        state_d = ST_RD;
                        dw_d    = lut_dw;
                        ltd_d   = 1'b1;
                    end else if (pre_rem == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD: begin
                w_rd_en = 1'b1;
                w_addr  = idx_q;
                state_d = ST_WR;
            end
            ST_WR: begin
                w_wr_en = 1'b1;
                w_addr  = idx_q;
                w_wdata = W_WIDTH'(sat_add(32'(w_rdata), 32'(dw_q), ltd_q, W_WIDTH));
                if (ltd_q) begin
                    state_d = ST_LTD_SCAN;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LTP_SCAN;
                    idx_d   = idx_q + A_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (kill) begin
            state_d = ST_IDLE;
            w_rd_en = 1'b0;
            w_wr_en = 1'b0;
            w_addr  = '0;
            w_wdata = '0;
        end
    end

    // Busy whenever a walk is in progress or an event still waits.
    always_comb begin
        o_wait = (state_q != ST_IDLE) || post_pend_q || (|pre_pend_q);
    end

    // State register; reset leaves everything idle with stale ages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pre_age_q   <= '{default: AGE_STALE};
            snap_q      <= '{default: AGE_STALE};
            post_age_q  <= AGE_STALE;
            pre_pend_q  <= '0;
            post_pend_q <= 1'b0;
            dw_q        <= '0;
            ltd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pre_age_q   <= pre_age_d;
            snap_q      <= snap_d;
            post_age_q  <= post_age_d;
            pre_pend_q  <= pre_pend_d;
            post_pend_q <= post_pend_d;
            dw_q        <= dw_d;
            ltd_q       <= ltd_d;
        end
    end

endmodule

// File: tb/tb_stdp_update_unit.sv
// Directed bench for stdp_update_unit with a synchronous weight memory.
module tb_stdp_update_unit;

    localparam int N_SYN   = 8;
    localparam int W_WIDTH = 8;
    localparam int T_WIDTH = 6;
    localparam int A_W     = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               kill = 1'b0;
    logic               tick = 1'b0;
    logic [1:0]         mode = 2'b11;
    logic [N_SYN-1:0]   pre_spike = '0;
    logic               post_spike = 1'b0;
    logic               w_rd_en;
    logic               w_wr_en;
    logic [A_W-1:0]     w_addr;
    logic [W_WIDTH-1:0] w_rdata = '0;
    logic [W_WIDTH-1:0] w_wdata;
    logic               o_wait;

    logic [W_WIDTH-1:0] mem [N_SYN];
    int rd_count = 0;
    int wr_count = 0;
    int overlap_count = 0;
    int last_wr_addr = -1;
    int last_wr_data = -1;
    int check_count = 0;
    int pass_count = 0;
    int k;

    stdp_update_unit #(
        .N_SYN     (N_SYN),
        .W_WIDTH   (W_WIDTH),
        .T_WIDTH   (T_WIDTH),
        .BIN_SHIFT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kill       (kill),
        .tick       (tick),
        .mode       (mode),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .w_rd_en    (w_rd_en),
        .w_wr_en    (w_wr_en),
        .w_addr     (w_addr),
        .w_rdata    (w_rdata),
        .w_wdata    (w_wdata),
        .o_wait     (o_wait)
    );

    always #5 clk = ~clk;

    // Synchronous weight memory: read data one cycle after the strobe.
    always @(posedge clk) begin
        if (w_rd_en && w_wr_en) overlap_count++;
        if (w_rd_en) begin
            w_rdata <= mem[w_addr];
            rd_count++;
        end
        if (w_wr_en) begin
            mem[w_addr] <= w_wdata;
            wr_count++;
            last_wr_addr = int'(w_addr);
            last_wr_data = int'(w_wdata);
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs from a negedge and returns on the next negedge.
    task automatic applyStimulus(input logic k_v, input logic [N_SYN-1:0] pre_v,
                                 input logic post_v, input logic tick_v);
        kill       = k_v;
        pre_spike  = pre_v;
        post_spike = post_v;
        tick       = tick_v;
        @(negedge clk);
        kill       = 1'b0;
        pre_spike  = '0;
        post_spike = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic kill_and_clear();
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        rd_count     = 0;
        wr_count     = 0;
        last_wr_addr = -1;
        last_wr_data = -1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (o_wait && n < budget) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        checkOutput(tag, int'(o_wait), 0);
    endtask

    initial begin
        for (int i = 0; i < N_SYN; i++) mem[i] = 8'd50;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_rd_en", int'(w_rd_en), 0);
        checkOutput("rst_wr_en", int'(w_wr_en), 0);
        checkOutput("rst_addr", int'(w_addr), 0);
        checkOutput("rst_wdata", int'(w_wdata), 0);
        checkOutput("rst_wait", int'(o_wait), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LTP: pre ch3, 5 ticks, post -> +6
        $display("[TB] LTP bin 1 on channel 3");
        kill_and_clear();
        mem[3] = 8'd100;
        applyStimulus(1'b0, 8'b0000_1000, 1'b0, 1'b0);
        do_ticks(5);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("ltp_wait_high", int'(o_wait), 1);
        k = 0;
        while (!w_rd_en && k < 20) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        checkOutput("ltp_rd_latency", k, 5);
        checkOutput("ltp_rd_addr", int'(w_addr), 3);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("ltp_wr_en", int'(w_wr_en), 1);
        checkOutput("ltp_wr_no_rd", int'(w_rd_en), 0);
        checkOutput("ltp_wdata", int'(w_wdata), 106);
        wait_idle("ltp_idle", 40);
        checkOutput("ltp_wr_count", wr_count, 1);
        checkOutput("ltp_rd_count", rd_count, 1);
        checkOutput("ltp_mem3", int'(mem[3]), 106);

        // LTD: post, 2 ticks, pre ch0 -> -6 clamped to 0
        $display("[TB] LTD clamp low on channel 0");
        kill_and_clear();
        mem[0] = 8'd3;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        do_ticks(2);
        applyStimulus(1'b0, 8'b0000_0001, 1'b0, 1'b0);
        wait_idle("ltd_idle", 40);
        checkOutput("ltd_wr_count", wr_count, 1);
        checkOutput("ltd_wr_addr", last_wr_addr, 0);
        checkOutput("ltd_wdata", last_wr_data, 0);

        // LTP clamp high: pre ch5, 1 tick, post, 253 + 8
        $display("[TB] LTP clamp high on channel 5");
        kill_and_clear();
        mem[5] = 8'd253;
        applyStimulus(1'b0, 8'b0010_0000, 1'b0, 1'b0);
        do_ticks(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        wait_idle("sat_idle", 40);
        checkOutput("sat_wr_count", wr_count, 1);
        checkOutput("sat_wr_addr", last_wr_addr, 5);
        checkOutput("sat_wdata", last_wr_data, 255);

        // Simultaneous pre ch1 and post -> no access, quick drain
        $display("[TB] simultaneous spikes");
        kill_and_clear();
        applyStimulus(1'b0, 8'b0000_0010, 1'b1, 1'b0);
        wait_idle("sim_idle_in_budget", N_SYN + 3);
        checkOutput("sim_rd_count", rd_count, 0);
        checkOutput("sim_wr_count", wr_count, 0);

        // Out of window: pre ch2, 40 ticks, post
        $display("[TB] outside window");
        kill_and_clear();
        applyStimulus(1'b0, 8'b0000_0100, 1'b0, 1'b0);
        do_ticks(40);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        wait_idle("win_idle", 40);
        checkOutput("win_rd_count", rd_count, 0);
        checkOutput("win_wr_count", wr_count, 0);

        // LTP-only mode suppresses LTD
        $display("[TB] mode LTP only");
        kill_and_clear();
        mode = 2'b01;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        do_ticks(3);
        applyStimulus(1'b0, 8'b0001_0000, 1'b0, 1'b0);
        wait_idle("mode_idle", 40);
        checkOutput("mode_rd_count", rd_count, 0);
        checkOutput("mode_wr_count", wr_count, 0);
        mode = 2'b11;

        // Kill during RD aborts the write and leaves ages stale
        $display("[TB] kill during read");
        kill_and_clear();
        mem[3] = 8'd100;
        applyStimulus(1'b0, 8'b0000_1000, 1'b0, 1'b0);
        do_ticks(5);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        k = 0;
        while (!w_rd_en && k < 20) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        checkOutput("kill_reached_rd", int'(w_rd_en), 1);
        rd_count = 0;
        wr_count = 0;
        kill = 1'b1;
        #1;
        checkOutput("kill_rd_gated", int'(w_rd_en), 0);
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill_wait_low", int'(o_wait), 0);
        checkOutput("kill_no_wr_en", int'(w_wr_en), 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        wait_idle("kill_post_idle", 40);
        checkOutput("kill_wr_count", wr_count, 0);
        checkOutput("kill_rd_count", rd_count, 0);
        checkOutput("kill_mem3", int'(mem[3]), 100);

        checkOutput("strobe_overlap", overlap_count, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Absolute time guard so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/stdp_update_unit.md
# stdp_update_unit

Parametrised STDP engine for one physical post-neuron: tracks per-synapse pre-spike age and post-spike age, and on each spike event walks the affected synapses, reads the weight, adds the quantised STDP delta and writes back with saturation. It supersedes the fixed 8-bit single-pair STDP block. It adds N-channel support, a configurable time window, LTP/LTD mode selection and a read/write port to the neuron's weight memory.

## Interface
- N_SYN, 8, number of pre-synaptic channels (≥2)
- W_WIDTH, 8, unsigned weight width (≥4)
- T_WIDTH, 6, age counter width; all-ones = stale
- BIN_SHIFT, 2, delta → LUT bin = delta >> BIN_SHIFT; 8 bins, window = 8<<BIN_SHIFT ticks
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-low
- kill  in  1  synchronous abort/flush, active-high
- tick  in  1  one simulation timestep elapsed
- mode  in  2  00 off, 01 LTP only, 10 LTD only, 11 both
- pre_spike  in  N_SYN  per-channel pre spike, 1-cycle pulse
- post_spike  in  1  post-neuron spike, 1-cycle pulse
- w_rd_en  out  1  weight read strobe
- w_wr_en  out  1  weight write strobe
- w_addr  out  clog2(N_SYN)  synapse index for read/write
- w_rdata  in  W_WIDTH  read data, valid the cycle after w_rd_en
- w_wdata  out  W_WIDTH  write data, valid with w_wr_en
- o_wait  out  1  high while FSM not IDLE or any event pending

## Operation
- Ages: pre_age[i], post_age. A spike sets age to 0. Otherwise tick increments, saturating at 2^T_WIDTH−1. Spike wins over tick in the same cycle. Ages update every cycle regardless of FSM state.
- Pending: post_spike sets post_pend. pre_spike[i] sets pre_pend[i]. Both OR-accumulate while busy. A spike coinciding with its own clear is kept.
- Eligibility: delta = age of opposite side, captured at the event. Update only if 1 ≤ delta < window and the mode bit is set. delta 0 (simultaneous) or ≥ window → skip, no memory access.
- FSM states: IDLE, LTP_SCAN, LTD_SCAN, RD, WR.
- IDLE: post_pend → LTP_SCAN with idx 0 and a snapshot of pre_age[] and post_pend cleared. Else any pre_pend → LTD_SCAN with lowest set index. Post is served first.
- LTP_SCAN: evaluates idx, 1 cycle. Eligible → RD. Else idx+1. After idx N_SYN−1 → IDLE.
- LTD_SCAN: takes the lowest pre_pend bit i and clears it, using current post_age. Eligible → RD. Else stay in LTD_SCAN or go to IDLE when no bits remain.
- RD: w_rd_en=1, w_addr=idx. Next state WR.
- WR: w_wr_en=1, w_wdata = sat(w_rdata ± dw). Return to the originating SCAN state with idx+1.
- LUT: LTP dw = {8,6,4,3,2,1,1,0}[bin]. LTD dw = {6,4,3,2,1,1,0,0}[bin].
- Arithmetic: extend to W_WIDTH+1 bits signed, clamp to [0, 2^W_WIDTH−1].
- mode=00: events are consumed and cleared with no memory access.
- kill: FSM → IDLE, all pend cleared, all ages set to stale. No strobe in the kill cycle or after it. A WR aborted by kill does not write.
- Reset: same as kill. All outputs 0, ages stale.

## Timing
- post_spike at edge 0 → LTP_SCAN at edge 1. First possible w_rd_en at edge 2.
- Per updated synapse: SCAN 1 + RD 1 + WR 1 cycles. Skipped synapse: 1 cycle.
- Full LTP pass: N_SYN cycles plus 2 per update.
- w_rd_en and w_wr_en are never high in the same cycle. Strobes are 1-cycle pulses.
- o_wait rises the cycle after the first spike and falls in the IDLE cycle with nothing pending.

## Structure
- stdp_pkg: state enum, LTP/LTD LUT constants, mode encodings, saturating add function.
- Sub-module stdp_lut: combinational delta + sign → dw, parametrised by BIN_SHIFT.

## Test plan
- Pre ch3, 5 ticks, post, w[3]=100, mode 11 → one RD/WR at addr 3, wdata 106 (bin 1, +6). No other writes.
- Post, 2 ticks, pre ch0, w[0]=3 → wdata 0 (−6, clamped low).
- Pre ch5, 1 tick, post, w[5]=253 → wdata 255 (+8, clamped high).
- Pre ch1 and post in the same cycle → no w_rd_en / w_wr_en. o_wait returns low within N_SYN+3 cycles.
- Pre ch2, 40 ticks (≥ window 32), post → no write. Mode 01 with post then pre ch4 after 3 ticks → no LTD write.
- kill asserted in an RD cycle → no w_wr_en afterwards. o_wait low next cycle. A later post with no new pre → no writes (ages stale).
